// File: rtl/dual_wb_queue.sv
// Write-back queue between the dual-ALU execute stage and the single-write-port
// register file: takes up to two results per cycle and retires them in program order.
module dual_wb_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          valid_1,
    input  logic [4:0]    dest_1,
    input  logic [31:0]   ALU_1,
    input  logic          valid_2,
    input  logic [4:0]    dest_2,
    input  logic [31:0]   ALU_2,
    output logic          in_ready,
    output logic          wr_en,
    output logic [4:0]    wr_addr,
    output logic [31:0]   wr_data,
    input  logic [4:0]    query_a,
    input  logic [4:0]    query_b,
    output logic          pending_a,
    output logic          pending_b,
    output logic          overflow_err,
    output logic [AW:0]   count
);

    localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH - 2);

    logic [4:0]    mem_dest_q [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [AW-1:0] head_q, tail_q, tail_d, tail_p1;
    logic [AW:0]   count_q, count_d, push_cnt, pop_cnt;
    logic          wr_en_q, overflow_q;
    logic [4:0]    wr_addr_q;
    logic [31:0]   wr_data_q;

    logic          acc_1, acc_2, push_reject, pop;
    logic          we_0, we_1;
    logic [4:0]    wdest_0, wdest_1;
    logic [31:0]   wdata_0, wdata_1;
    logic [DEPTH-1:0] occ;
    logic          hit_a, hit_b;

    // Handshake: the producer may present valid_1/valid_2 in any cycle; a slot is
    // taken only while in_ready is high (room for two). Presenting either valid
    // while in_ready is low drops both slots and latches overflow_err.
    assign in_ready    = (count_q <= READY_MAX);
    assign push_reject = (valid_1 | valid_2) & ~in_ready;
    assign acc_1       = valid_1 & in_ready & (dest_1 != 5'd0);
    assign acc_2       = valid_2 & in_ready & (dest_2 != 5'd0);
    assign pop         = (count_q != '0);
    assign tail_p1     = tail_q + AW'(1);

    always_comb begin
        we_0     = 1'b0;
        we_1     = 1'b0;
        wdest_0  = dest_1;
        wdata_0  = ALU_1;
        wdest_1  = dest_2;
        wdata_1  = ALU_2;
        push_cnt = '0;
        tail_d   = tail_q;
        if (acc_1 && acc_2) begin
            we_0     = 1'b1;
            we_1     = 1'b1;
            push_cnt = (AW+1)'(2);
            tail_d   = tail_q + AW'(2);
        end else if (acc_1 || acc_2) begin
            // A lone survivor always lands at tail, whichever slot it came from.
            we_0     = 1'b1;
            wdest_0  = acc_1 ? dest_1 : dest_2;
            wdata_0  = acc_1 ? ALU_1 : ALU_2;
            push_cnt = (AW+1)'(1);
            tail_d   = tail_p1;
        end
        pop_cnt = pop ? (AW+1)'(1) : '0;
        count_d = count_q + push_cnt - pop_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            if (we_0) begin
                mem_dest_q[tail_q] <= wdest_0;
                mem_data_q[tail_q] <= wdata_0;
            end
            if (we_1) begin
                mem_dest_q[tail_p1] <= wdest_1;
                mem_data_q[tail_p1] <= wdata_1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wr_en_q <= 1'b0;
        end else begin
            if (push_reject) begin
                overflow_q <= 1'b1;
            end
            tail_q  <= tail_d;
            count_q <= count_d;
            if (pop) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= mem_dest_q[head_q];
                wr_data_q <= mem_data_q[head_q];
                head_q    <= head_q + AW'(1);
            end else begin
                wr_en_q <= 1'b0;
            end
        end
    end

    // Entry g is live when its distance from head (mod DEPTH) is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_occ
        assign occ[g] = ({1'b0, AW'(g) - head_q} < count_q);
    end

    always_comb begin
        hit_a = wr_en_q && (wr_addr_q == query_a);
        hit_b = wr_en_q && (wr_addr_q == query_b);
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && (mem_dest_q[i] == query_a)) hit_a = 1'b1;
            if (occ[i] && (mem_dest_q[i] == query_b)) hit_b = 1'b1;
        end
    end

    assign pending_a    = (query_a != 5'd0) && hit_a;
    assign pending_b    = (query_b != 5'd0) && hit_b;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign overflow_err = overflow_q;
    assign count        = count_q;

endmodule

// File: tb/tb_dual_wb_queue.sv
// Directed bench for dual_wb_queue: ordering, register-0 filter, backpressure,
// flush/reset mid-drain and steady-state throughput.
module tb_dual_wb_queue;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        valid_1, valid_2;
    logic [4:0]  dest_1, dest_2;
    logic [31:0] ALU_1, ALU_2;
    logic        in_ready, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  query_a, query_b;
    logic        pending_a, pending_b, overflow_err;
    logic [3:0]  count;

    int n_cmp  = 0;
    int n_fail = 0;

    dual_wb_queue #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .valid_1(valid_1), .dest_1(dest_1), .ALU_1(ALU_1),
        .valid_2(valid_2), .dest_2(dest_2), .ALU_2(ALU_2),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .query_a(query_a), .query_b(query_b),
        .pending_a(pending_a), .pending_b(pending_b),
        .overflow_err(overflow_err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_1 = 1'b0; dest_1 = '0; ALU_1 = '0;
        valid_2 = 1'b0; dest_2 = '0; ALU_2 = '0;
    endtask

    task automatic drive(input logic v1, input logic [4:0] d1, input logic [31:0] a1,
                         input logic v2, input logic [4:0] d2, input logic [31:0] a2);
        valid_1 = v1; dest_1 = d1; ALU_1 = a1;
        valid_2 = v2; dest_2 = d2; ALU_2 = a2;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; query_a = '0; query_b = '0;
        idle_inputs();
        tick(); tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_ovf", 32'(overflow_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Single push, two-edge latency, hazard until write issues
        drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
        tick(); idle_inputs();
        check("single_count", 32'(count), 32'd1);
        check("single_wr_en0", 32'(wr_en), 32'd0);
        query_a = 5'd5; #1;
        check("single_pend_q", 32'(pending_a), 32'd1);
        tick();
        check("single_wr_en", 32'(wr_en), 32'd1);
        check("single_wr_addr", 32'(wr_addr), 32'd5);
        check("single_wr_data", wr_data, 32'h1234);
        check("single_count0", 32'(count), 32'd0);
        check("single_pend_w", 32'(pending_a), 32'd1);
        tick();
        check("single_idle_en", 32'(wr_en), 32'd0);
        check("single_hold_addr", 32'(wr_addr), 32'd5);
        check("single_pend_off", 32'(pending_a), 32'd0);

        // Dual push ordering
        drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB);
        tick(); idle_inputs();
        check("dual_count", 32'(count), 32'd2);
        tick();
        check("dual_w1_addr", 32'(wr_addr), 32'd3);
        check("dual_w1_data", wr_data, 32'hAAAA);
        check("dual_w1_count", 32'(count), 32'd1);
        tick();
        check("dual_w2_en", 32'(wr_en), 32'd1);
        check("dual_w2_addr", 32'(wr_addr), 32'd4);
        check("dual_w2_data", wr_data, 32'hBBBB);
        tick();
        check("dual_idle", 32'(wr_en), 32'd0);

        // Register-0 filter; slot 2 survives alone
        drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd7, 32'h7777);
        tick(); idle_inputs();
        query_a = 5'd0; query_b = 5'd7; #1;
        check("r0_count", 32'(count), 32'd1);
        check("r0_pend_a", 32'(pending_a), 32'd0);
        check("r0_pend_b", 32'(pending_b), 32'd1);
        tick();
        check("r0_addr", 32'(wr_addr), 32'd7);
        check("r0_data", wr_data, 32'h7777);
        tick();
        check("r0_idle", 32'(wr_en), 32'd0);

        // Duplicate destinations: both written, in order
        drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2);
        tick(); idle_inputs();
        query_a = 5'd9; #1;
        check("dup_pend", 32'(pending_a), 32'd1);
        tick();
        check("dup_w1", wr_data, 32'h1);
        tick();
        check("dup_w2", wr_data, 32'h2);
        check("dup_w2_addr", 32'(wr_addr), 32'd9);
        tick();
        query_a = '0; query_b = '0;

        // Fill two per cycle: entry j has dest j+1, data 0x100+j
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 5'(2*k+1), 32'h100 + 32'(2*k), 1'b1, 5'(2*k+2), 32'h100 + 32'(2*k+1));
            #1;
            check("fill_ready", 32'(in_ready), 32'd1);
            tick();
            check("fill_count", 32'(count), 32'(k+2));
            check("fill_wr_en", 32'(wr_en), (k >= 1) ? 32'd1 : 32'd0);
            if (k >= 1) check("fill_addr", 32'(wr_addr), 32'(k));
        end
        idle_inputs(); #1;
        check("full_not_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 5'd20, 32'hBAD0, 1'b0, 5'd0, 32'h0);
        tick(); idle_inputs();
        check("ovf_set", 32'(overflow_err), 32'd1);
        check("ovf_count", 32'(count), 32'd6);
        check("ovf_addr", 32'(wr_addr), 32'd6);
        check("ovf_data", wr_data, 32'h105);
        for (int j = 6; j < 12; j++) begin
            tick();
            check("drain_en", 32'(wr_en), 32'd1);
            check("drain_addr", 32'(wr_addr), 32'(j+1));
            check("drain_data", wr_data, 32'h100 + 32'(j));
            check("drain_count", 32'(count), 32'(11-j));
        end
        tick();
        check("drain_idle", 32'(wr_en), 32'd0);
        check("ovf_sticky", 32'(overflow_err), 32'd1);

        // Flush with 5 entries queued (13..17)
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'(10+2*k), 32'h300 + 32'(k), 1'b1, 5'(11+2*k), 32'h380 + 32'(k));
            tick();
        end
        idle_inputs();
        check("pre_flush_count", 32'(count), 32'd5);
        check("pre_flush_addr", 32'(wr_addr), 32'd12);
        query_a = 5'd15; query_b = 5'd13; #1;
        check("pre_flush_pend_a", 32'(pending_a), 32'd1);
        check("pre_flush_pend_b", 32'(pending_b), 32'd1);
        flush = 1'b1;
        tick(); flush = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_wr_en", 32'(wr_en), 32'd0);
        check("flush_pend_a", 32'(pending_a), 32'd0);
        check("flush_pend_b", 32'(pending_b), 32'd0);
        check("flush_ovf_kept", 32'(overflow_err), 32'd1);
        tick();
        check("flush_no_write", 32'(wr_en), 32'd0);

        // Reset mid-drain
        drive(1'b1, 5'd21, 32'h21, 1'b1, 5'd22, 32'h22);
        tick();
        drive(1'b1, 5'd23, 32'h23, 1'b1, 5'd24, 32'h24);
        tick(); idle_inputs();
        check("pre_rst_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        query_a = 5'd22; #1;
        check("mrst_count", 32'(count), 32'd0);
        check("mrst_wr_en", 32'(wr_en), 32'd0);
        check("mrst_wr_addr", 32'(wr_addr), 32'd0);
        check("mrst_wr_data", wr_data, 32'd0);
        check("mrst_ovf", 32'(overflow_err), 32'd0);
        check("mrst_pend", 32'(pending_a), 32'd0);
        tick();
        check("mrst_no_write", 32'(wr_en), 32'd0);
        query_a = '0;

        // Steady one push per cycle
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'(i+1), 32'h2000 + 32'(i), 1'b0, 5'd0, 32'h0);
            tick();
            check("steady_count", 32'(count), 32'd1);
            check("steady_en", 32'(wr_en), (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) check("steady_data", wr_data, 32'h2000 + 32'(i-1));
        end
        idle_inputs();
        tick();
        check("steady_last_addr", 32'(wr_addr), 32'd20);
        check("steady_last_data", wr_data, 32'h2013);
        check("steady_last_count", 32'(count), 32'd0);
        tick();
        check("steady_idle", 32'(wr_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_wb_queue.md
Name: dual_wb_queue

Overview:
- Write-back stage behind the dual-ALU execute stage.
- Accepts up to two ALU results per cycle: slot 1 is older than slot 2.
- Buffers the results in order in a FIFO and drains them one per cycle into the single-write-port register file.
- Reports pending destinations so decode can stall on RAW hazards.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 4
AW, 3, pointer width; log2(DEPTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  synchronous queue clear
valid_1  in  1  slot-1 result valid
dest_1  in  5  slot-1 destination register
ALU_1  in  32  slot-1 result
valid_2  in  1  slot-2 result valid
dest_2  in  5  slot-2 destination register
ALU_2  in  32  slot-2 result
in_ready  out  1  queue can take two results this cycle
wr_en  out  1  register-file write enable (registered)
wr_addr  out  5  register-file write address (registered)
wr_data  out  32  register-file write data (registered)
query_a  in  5  decode source A register
query_b  in  5  decode source B register
pending_a  out  1  write to query_a outstanding
pending_b  out  1  write to query_b outstanding
overflow_err  out  1  sticky: push attempted while in_ready=0
count  out  AW+1  current occupancy

Behaviour:
- Reset (rst_n=0 at an edge) clears:
  - count, head and tail pointers: 0
  - wr_en, wr_addr, wr_data, overflow_err: 0
  - Priority: rst_n > flush > normal operation.
- Reset or flush mid-drain discards all queued entries; no partial write is issued.
- Flush clears count, pointers and wr_en at the edge. overflow_err is not cleared by flush.
- in_ready is combinational: 1 iff (DEPTH - count) >= 2. It does not depend on the pop in the same cycle.
- Push qualification:
  - slot k is accepted iff valid_k && in_ready && dest_k != 0.
  - A result to register 0 is dropped silently.
  - Any valid_k high while in_ready=0 discards both slots for that cycle and sets overflow_err=1 until reset.
- Push order:
  - If both slots are accepted, slot 1 is written at tail and slot 2 at tail+1; tail advances by 2.
  - If one slot is accepted, it is written at tail; tail advances by 1.
  - valid_2 without valid_1 is legal.
- Pop:
  - At each edge, if count>0 (pre-edge value), head is copied to the wr_* registers with wr_en=1 and head advances.
  - Otherwise wr_en=0; wr_addr and wr_data hold their previous values.
- Simultaneous push and pop: count_next = count + pushes - pop. At most +2 and -1 per edge.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH.
- Latency: a result pushed into an empty queue at edge k appears with wr_en=1 during the cycle after edge k+1, i.e. two edges from input to write.
- Ordering: register-file write order equals program order (slot 1 before slot 2, earlier cycles first).
- Hazard flags are combinational:
  - pending_x = 1 iff query_x != 0 and any of:
    - any occupied FIFO entry has dest == query_x, or
    - wr_en=1 and wr_addr == query_x.
  - Same-cycle incoming results are not included.
  - Duplicate destinations in the queue are allowed; all are written, in order, so the last write wins.

Test Plan:
- Reset, then single push: valid_1=1, dest_1=5, ALU_1=0x1234 at one edge. -> count=1; at the next edge wr_en=1, wr_addr=5, wr_data=0x1234; count=0; pending_a=1 for query_a=5 until wr_en drops.
- Dual push ordering: dest_1=3/0xAAAA and dest_2=4/0xBBBB in the same cycle. -> writes of reg 3 then reg 4 on consecutive cycles; never reversed.
- Register-0 filter: valid_1=1, dest_1=0; valid_2=1, dest_2=7. -> only reg 7 is written; count increments by 1; pending_a=0 for query_a=0.
- Fill and backpressure: push two per cycle with DEPTH=8. -> in_ready falls once count reaches 7. One further valid push while in_ready=0 sets overflow_err=1 and leaves count unchanged; entries drain 0..N in order with pointer wrap.
- Flush mid-drain: 5 queued entries, assert flush one cycle. -> next cycle count=0, wr_en=0, pending flags 0; overflow_err unchanged. Reset mid-drain gives the same result and also clears overflow_err.
- Steady push/pop: one push per cycle for 20 cycles. -> count stays at 1 and a write is issued every cycle.
